// File: rtl/dffq_chain_pkg.sv
// Shared state encoding and sizing helpers for the dffq chain load/readback controller.
package dffq_chain_pkg;

    localparam int unsigned ST_IDLE   = 0;
    localparam int unsigned ST_SHIFT  = 1;
    localparam int unsigned ST_UPDATE = 2;
    localparam int unsigned ST_RESP   = 3;
    localparam int unsigned N_ST      = 4;

    // One-hot: each state owns one flop so SE/UPD/RSP_VALID come straight off a register.
    typedef enum logic [N_ST-1:0] {
        S_IDLE   = 4'b0001,
        S_SHIFT  = 4'b0010,
        S_UPDATE = 4'b0100,
        S_RESP   = 4'b1000
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/dffq_chain_shreg.sv
// Parallel-load / serial-shift register with a bit counter; captures the chain tail MSB-first.
module dffq_chain_shreg
    import dffq_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             clear,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over load, load over shift; shift moves toward bit 0 and fills the MSB.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (clear) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (load) begin
            q_d   = load_data;
            cnt_d = '0;
        end else if (shift) begin
            q_d   = WIDTH'({serial_in, q_q} >> 1);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q     = q_q;
    assign count = cnt_q;
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/dffq_chain_ctrl.sv
// Sequencer: accepts a word, shifts it into the external dffq chain, strobes UPD, returns the old contents.
module dffq_chain_ctrl
    import dffq_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] REQ_DATA,
    input  logic             ABORT,
    output logic             SE,
    output logic             SD,
    input  logic             SQ,
    output logic             UPD,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             load, shift, clear;
    logic [WIDTH-1:0] sh_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             full;

    // Guard against a shift past the chain length should the FSM ever linger in SHIFT.
    assign full = (cnt == CNT_W'(WIDTH));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID && req_ready_q) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ABORT) begin
                    clear   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    shift = !full;
                    if (last) begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // READY stays low through reset and rises on the first edge after release.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
        end
    end

    dffq_chain_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk       (CLK),
        .rst_n     (RN),
        .load      (load),
        .load_data (REQ_DATA),
        .shift     (shift),
        .clear     (clear),
        .serial_in (SQ),
        .q         (sh_q),
        .count     (cnt),
        .last      (last)
    );

    assign REQ_READY = req_ready_q;
    assign SE        = state_q[ST_SHIFT];
    assign UPD       = state_q[ST_UPDATE];
    assign RSP_VALID = state_q[ST_RESP];
    assign SD        = sh_q[0];
    assign RSP_DATA  = sh_q;

endmodule
